// File: rtl/rioctrl_io_filter.sv
// rioctrl_io_filter
//
// Frame-level companion for the bob5x serial I/O shifter. It sits on the
// shifter's parallel side. At every frame boundary it captures the completed
// input word and debounces each bit across frames. It reports edges of the
// debounced bits and stages the next output word so a frame never shifts a
// torn value. A watchdog flags a stalled or missing shifter.
//
// A frame boundary is the falling edge of the shifter's load strobe, seen
// in the clk domain.
//
// Parameters:
//   WIDTH     bits per frame (must match the shifter)
//   FILTER    frames a new raw value must persist before in_filt follows (1..255)
//   TIMEOUT   clk cycles without a frame before stale asserts (2..2^32-1)
//   OUT_INIT  reset value of shift_data_out
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   shift_data_in   parallel input word from the shifter
//   shift_load      shifter load strobe (idle high, low at frame end)
//   out_word        output word requested by application logic
//   shift_data_out  word fed to the shifter, updated only at frame boundaries
//   in_filt         debounced input word
//   in_rise         one-cycle pulse per bit, in_filt bit went 0->1
//   in_fall         one-cycle pulse per bit, in_filt bit went 1->0
//   frame_tick      one-cycle pulse per accepted frame
//   frame_count     accepted frames, wraps at 16 bits
//   stale           no frame seen for TIMEOUT cycles

module rioctrl_io_filter #(
    parameter int               WIDTH    = 8,
    parameter int               FILTER   = 3,
    parameter logic [31:0]      TIMEOUT  = 32'd50000000,
    parameter logic [WIDTH-1:0] OUT_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] shift_data_in,
    input  logic             shift_load,
    input  logic [WIDTH-1:0] out_word,
    output logic [WIDTH-1:0] shift_data_out,
    output logic [WIDTH-1:0] in_filt,
    output logic [WIDTH-1:0] in_rise,
    output logic [WIDTH-1:0] in_fall,
    output logic             frame_tick,
    output logic [15:0]      frame_count,
    output logic             stale
);

    localparam int            CW       = $clog2(FILTER + 1);
    localparam logic [CW:0]   FILTER_C = (CW + 1)'(FILTER);

    logic                      load_q;
    logic                      frame;
    logic [WIDTH-1:0][CW-1:0]  cnt;
    logic [31:0]               wd;

    // load_q resets high so that releasing reset with load idle cannot look
    // like a falling edge. Holding load low gives exactly one frame.
    assign frame = ~shift_load & load_q;

    // Previous value of the load strobe, used for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 1'b1;
        end else begin
            load_q <= shift_load;
        end
    end

    // Per-bit debounce. A bit must disagree with in_filt on FILTER
    // consecutive frames before it is accepted. Any agreeing frame restarts
    // the count, which rejects bounces. Edge pulses last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_filt <= '0;
            in_rise <= '0;
            in_fall <= '0;
            cnt     <= '0;
        end else begin
            in_rise <= '0;
            in_fall <= '0;
            if (frame) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (shift_data_in[i] == in_filt[i]) begin
                        cnt[i] <= '0;
                    end else if ((CW + 1)'(cnt[i]) + (CW + 1)'(1) == FILTER_C) begin
                        in_filt[i] <= shift_data_in[i];
                        cnt[i]     <= '0;
                        in_rise[i] <= shift_data_in[i];
                        in_fall[i] <= ~shift_data_in[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Output staging and frame bookkeeping. The shifter idles in its reload
    // state at the boundary, so loading out_word here means the next frame
    // shifts one consistent word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_data_out <= OUT_INIT;
            frame_tick     <= 1'b0;
            frame_count    <= '0;
        end else begin
            frame_tick <= frame;
            if (frame) begin
                shift_data_out <= out_word;
                frame_count    <= frame_count + 16'd1;
            end
        end
    end

    // Frame watchdog. It saturates at TIMEOUT and raises stale on the edge
    // where it gets there. A frame on that same edge takes priority, so
    // stale stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd    <= '0;
            stale <= 1'b0;
        end else if (frame) begin
            wd    <= '0;
            stale <= 1'b0;
        end else if (wd != TIMEOUT) begin
            wd <= wd + 32'd1;
            if (wd + 32'd1 == TIMEOUT) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rioctrl_io_filter.md
# rioctrl_io_filter

Frame-level companion for the bob5x serial I/O shifter. Sits directly on the shifter's parallel side: consumes the completed input word at every frame boundary, debounces it per bit across frames, emits edge events, and stages the output word so each shifted frame carries one consistent value. Also runs a frame watchdog so plugin logic can detect a stalled or missing shifter.

## Interface
- WIDTH, 8, bits per frame; must match the shifter's WIDTH
- FILTER, 3, consecutive frames a new raw value must persist before `in_filt` follows it; legal range 1..255, 1 = no filtering
- TIMEOUT, 50000000, clk cycles without a frame boundary before `stale` asserts; legal range 2..2^32-1
- OUT_INIT, 0, reset value of `shift_data_out` (WIDTH bits)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- shift_data_in  in  WIDTH  parallel input word from shifter (`data_in`)
- shift_load  in  1  shifter `load` strobe (idle high, low for one shifter step at frame end)
- out_word  in  WIDTH  output word requested by application logic
- shift_data_out  out  WIDTH  word fed to shifter `data_out`
- in_filt  out  WIDTH  debounced input word
- in_rise  out  WIDTH  one-cycle pulse per bit, `in_filt` bit went 0->1
- in_fall  out  WIDTH  one-cycle pulse per bit, `in_filt` bit went 1->0
- frame_tick  out  1  one-cycle pulse per accepted frame
- frame_count  out  16  accepted frames, wraps 0xFFFF->0x0000
- stale  out  1  watchdog expired, no frame for TIMEOUT cycles

## Operation
- Same clock domain as shifter; no synchronisers on `shift_*`.
- `load_q` registers `shift_load`; reset value 1 so reset release never fakes an edge.
- Frame event F: edge where `shift_load`==0 and `load_q`==1 (falling edge of load). At that point all WIDTH bits of `shift_data_in` are valid and stable.
- Per bit i, counter `cnt[i]` of width clog2(FILTER+1). On F:
  - raw==in_filt[i]: cnt<=0.
  - raw!=in_filt[i] and cnt+1==FILTER: in_filt[i]<=raw, cnt<=0, set in_rise[i]/in_fall[i] by direction.
  - otherwise cnt<=cnt+1.
  - Any frame agreeing with in_filt restarts the count (bounce rejection).
- On F: shift_data_out<=out_word (sampled that edge); shifter idles in load-low/reload state, so next frame shifts the new word untorn. `out_word` changes between frames are not seen until next F.
- On F: frame_tick<=1, frame_count<=frame_count+1, watchdog<=0, stale<=0.
- Watchdog: 32-bit counter, +1 every cycle without F, saturates at TIMEOUT; stale<=1 the edge it reaches TIMEOUT. `in_filt` holds last value while stale.
- Simultaneous F and watchdog reaching TIMEOUT: F wins, stale stays/returns 0.
- shift_load held low indefinitely: exactly one F; no further events until load returns high then falls again.

## Timing
- Reset (rst_n low, async): in_filt=0, in_rise=0, in_fall=0, frame_tick=0, frame_count=0, stale=0, shift_data_out=OUT_INIT, all cnt=0, watchdog=0, load_q=1.
- All outputs registered. in_rise/in_fall/frame_tick/in_filt update on the F edge, visible for exactly one cycle (pulses) after it; pulses deassert next edge.
- Latency raw change -> in_filt: FILTER frame events, counted from first frame carrying the new value.
- shift_data_out valid from F+0 edge onward; shifter's first bit sample occurs ≥1 DIVIDER period later.
- Minimum spacing of F: 2 cycles (load must be seen high once); spec holds for any spacing ≥2.
- Reset asserted mid-frame: everything returns to reset values immediately; first F after release counts as frame 1.

## Test plan
- Reset/idle: hold rst_n low, shift_load=1 -> all outputs reset values, shift_data_out==OUT_INIT; release, no frame_tick for 100 cycles.
- Debounce, FILTER=3: raw 0x00->0x81 on frames 1..3 -> in_filt 0x00 after F1,F2, 0x81 after F3 with in_rise=0x81 for one cycle; then 0x01 for 3 frames -> in_fall=0x80 on F6.
- Bounce rejection, FILTER=3: raw 0x01,0x01,0x00,0x01,0x01 from in_filt=0 -> no change through F5; 0x01 on F6 -> in_filt=0x01.
- Output staging: out_word 0x5A, change to 0xA5 mid-frame -> shift_data_out stays 0x5A until next F, then 0xA5; frame_count increments once per F.
- Watchdog, TIMEOUT=20: no frames -> stale=1 on 20th cycle after last F; F at that same edge -> stale stays 0; later F clears stale.
- frame_count wrap: preload via 65536 frames (fast load toggling, period 2) -> 0xFFFF->0x0000; async reset mid-count -> 0 immediately.
